zion_fetch_queue: RTL and testbench
===================================

# zion_fetch_queue

Decoupling queue between the fetch stage and decode. It tracks one in-flight instruction-memory request issued by fetch and captures the returned instruction together with its PC. The pair is held in a small FIFO and presented to decode with a valid/ready handshake. It back-pressures fetch so the FIFO never overflows, and it discards wrong-path work when a branch/jump redirect occurs.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- iFetchEn  in  1  fetch issues an instruction-memory request this cycle.
- iPc  in  32  PC of the request issued this cycle.
- iInstr  in  32  instruction-memory read data; valid exactly one cycle after the request (synchronous memory).
- iFlush  in  1  redirect from the branch/jump bus (same signal as the fetch PC-set enable).
- oFetchStall  out  1  tells fetch to hold; requests are not accepted while high.
- oValid  out  1  head entry valid toward decode.
- oPc  out  32  PC of the head entry.
- oInstr  out  32  instruction of the head entry.
- iReady  in  1  decode accepts the head entry this cycle.

## Operation
- Accept: a request is accepted when iFetchEn=1, oFetchStall=0 and iFlush=0. On accept, reqVld_r←1 and reqPc_r←iPc; otherwise reqVld_r←0.
- Capture: when reqVld_r=1 and iFlush=0, entry {reqPc_r, iInstr} is pushed at the write pointer.
- Pop: when oValid=1 and iReady=1, the read pointer advances.
- Push and pop may occur in the same cycle; count is unchanged and both pointers advance.
- Count width is $clog2(DEPTH)+1. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- oFetchStall = (count + reqVld_r ≥ DEPTH). It is computed combinationally from registers only, with no path from iFetchEn, iReady or iFlush. The in-flight slot is always reserved, so a push never finds the FIFO full.
- Flush (iFlush=1) takes priority over every other event:
  - count←0, read/write pointers←0, reqVld_r←0.
  - A response arriving in the flush cycle is dropped.
  - A request presented in the flush cycle is dropped; fetch re-issues from the target PC on the next cycle.
  - A pop in the flush cycle is still honoured by decode, since decode sees oValid before the edge. The queue is nonetheless emptied.
- oValid = (count≠0). oPc/oInstr are driven from storage[rdPtr]. They are undefined-but-stable when oValid=0, and equal 0 after reset.
- Not checked: iReady asserted while oValid=0 has no effect.

## Timing
- Reset values: oValid=0, oPc=0, oInstr=0, oFetchStall=0; count, pointers, reqVld_r, reqPc_r and storage are all 0.
- Latency: request accepted at cycle t → pushed at the end of t+1 → oValid=1 at t+2 (queue empty, no flush). Minimum fetch-to-decode latency is 2 cycles.
- Throughput: 1 instruction/cycle sustained when iReady=1 continuously.
- Stall timing: with DEPTH=4, stall asserts in the cycle after the 4th accepted request when nothing is popped (count=3, reqVld_r=1). It deasserts in the cycle after a pop brings count+reqVld_r below DEPTH.
- Flush: the queue is empty (oValid=0) in cycle t+1 after iFlush at t. The first new-path instruction reaches oValid at t+3, given an accept at t+1.
- Reset mid-operation: all state clears asynchronously. Outputs reach their reset values without waiting for a clock edge.

## Structure
- The shared processor-component package holds:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - localparam FQ_DEFAULT_DEPTH=4
- Sub-module zion_fetch_fifo_core is a generic DEPTH-entry synchronous FIFO of fetch_entry_t. It has push, pop, clear, count, head outputs and async active-high reset.
- The top level contains only the in-flight register, the stall equation and flush gating.

## Test plan
- Single request: reset, then iFetchEn=1 with iPc=0x0000_1000 for one cycle, then iInstr=0x0000_0013 next cycle, iReady=1 → oValid=1 two cycles after the request with oPc=0x1000 and oInstr=0x13, then oValid=0.
- Back-pressure: DEPTH=4, iReady=0, iFetchEn=1 continuously with PCs 0x0,0x4,… → exactly 4 entries accepted and oFetchStall=1 thereafter. Then iReady=1 for 1 cycle → oPc=0x0 popped and stall drops the next cycle. No PC is lost or duplicated.
- Streaming: iReady=1 and iFetchEn=1 for 20 cycles with PCs 0x100..0x14C → 20 in-order outputs on consecutive cycles and oFetchStall never asserted.
- Flush: with 3 entries queued and one request in flight, pulse iFlush → oValid=0 the next cycle. The in-flight response and any request in the flush cycle never appear. The next accepted PC 0x2000 appears at oPc 2 cycles after its accept.
- Simultaneous push/pop at full: count=3, reqVld_r=1, iReady=1 → count remains 3 and the pointers wrap from 3 to 0 correctly across ≥2 laps.
- Async reset mid-stream: assert rst between clock edges while oValid=1 → oValid=0, oFetchStall=0, oPc=0 immediately. After release, the first request behaves as in scenario 1.

Source files
------------

// File: rtl/zion_fetch_queue_pkg.sv
// Shared fetch/decode types for the zion front end.
package zion_fetch_queue_pkg;

    localparam int FQ_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/zion_fetch_fifo_core.sv
// Generic DEPTH-entry synchronous FIFO of fetch entries with clear and async reset.
module zion_fetch_fifo_core
    import zion_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Clear wins over push/pop; callers never push into a full FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !clear_i) mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/zion_fetch_queue.sv
// Fetch-to-decode decoupling queue: one in-flight imem request plus a small FIFO.
module zion_fetch_queue
    import zion_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iFetchEn,
    input  logic [31:0] iPc,
    input  logic [31:0] iInstr,
    input  logic        iFlush,
    output logic        oFetchStall,
    output logic        oValid,
    output logic [31:0] oPc,
    output logic [31:0] oInstr,
    input  logic        iReady
);

    logic          req_vld_q, req_vld_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          accept, push, pop;
    fetch_entry_t  head, entry;

    // The in-flight slot counts as occupied so a returning response always fits.
    assign occupancy   = {1'b0, count} + (CW+1)'(req_vld_q);
    assign oFetchStall = (occupancy >= (CW+1)'(DEPTH));

    assign accept = iFetchEn && !oFetchStall && !iFlush;
    assign push   = req_vld_q && !iFlush;
    assign pop    = oValid && iReady;
    assign entry  = '{pc: req_pc_q, instr: iInstr};

    always_comb begin
        req_vld_d = accept;
        req_pc_d  = accept ? iPc : req_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_vld_q <= 1'b0;
            req_pc_q  <= '0;
        end else begin
            req_vld_q <= req_vld_d;
            req_pc_q  <= req_pc_d;
        end
    end

    zion_fetch_fifo_core #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .entry_i (entry),
        .pop_i   (pop),
        .clear_i (iFlush),
        .count_o (count),
        .head_o  (head)
    );

    assign oValid = (count != '0);
    assign oPc    = head.pc;
    assign oInstr = head.instr;

endmodule

// File: tb/tb_zion_fetch_queue.sv
// Directed bench for zion_fetch_queue: vector table plus hand-written corner sequences.
module tb_zion_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iFetchEn = 1'b0;
    logic [31:0] iPc = '0;
    logic [31:0] iInstr = '0;
    logic        iFlush = 1'b0;
    logic        iReady = 1'b0;
    logic        oFetchStall, oValid;
    logic [31:0] oPc, oInstr;

    int n_cmp = 0;
    int n_bad = 0;

    zion_fetch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .iFetchEn(iFetchEn), .iPc(iPc), .iInstr(iInstr),
        .iFlush(iFlush), .oFetchStall(oFetchStall), .oValid(oValid),
        .oPc(oPc), .oInstr(oInstr), .iReady(iReady)
    );

    always #5 clk = ~clk;

    // Instruction memory: each PC maps to a distinct word; 0x1000 -> 0x13.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc - 32'h0000_0FED;
    endfunction

    always_ff @(posedge clk) if (iFetchEn) iInstr <= instr_of(iPc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fe;
        logic [31:0] pc;
        logic        flush;
        logic        ready;
        logic        ev;
        logic        es;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fe, input logic [31:0] pc, input logic flush,
                                input logic ready, input logic ev, input logic es,
                                input logic [31:0] epc);
        vec_t v;
        v.fe = fe; v.pc = pc; v.flush = flush; v.ready = ready;
        v.ev = ev; v.es = es; v.epc = epc;
        return v;
    endfunction

    task automatic drive(input logic fe, input logic [31:0] pc, input logic flush, input logic ready);
        iFetchEn = fe; iPc = pc; iFlush = flush; iReady = ready;
    endtask

    // Each vector: outputs expected in that cycle, then the inputs applied in it.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 32'(oValid), 32'(vecs[i].ev));
            check($sformatf("v%0d_stall", i), 32'(oFetchStall), 32'(vecs[i].es));
            if (vecs[i].ev) begin
                check($sformatf("v%0d_pc", i), oPc, vecs[i].epc);
                check($sformatf("v%0d_instr", i), oInstr, instr_of(vecs[i].epc));
            end
            drive(vecs[i].fe, vecs[i].pc, vecs[i].flush, vecs[i].ready);
        end
    endtask

    initial begin
        logic [31:0] next_pc, exp_pc;
        int pops;
        logic rdy, fe;

        // single request
        vecs.push_back(mk(1, 32'h1000, 0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,    0, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,    0, 1, 1, 0, 32'h1000));
        vecs.push_back(mk(0, 32'h0,    0, 0, 0, 0, 32'h0));
        // back-pressure: four accepted, stall, one pop, refill, drain
        vecs.push_back(mk(1, 32'h0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h4,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h8,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'hC,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h10, 0, 1, 1, 1, 32'h0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 1, 0, 32'h4));
        vecs.push_back(mk(0, 32'h0,  0, 0, 1, 1, 32'h4));
        vecs.push_back(mk(0, 32'h0,  0, 1, 1, 1, 32'h4));
        vecs.push_back(mk(0, 32'h0,  0, 1, 1, 0, 32'h8));
        vecs.push_back(mk(0, 32'h0,  0, 1, 1, 0, 32'hC));
        vecs.push_back(mk(0, 32'h0,  0, 1, 1, 0, 32'h10));
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 0, 32'h0));

        #12;
        check("reset_valid", 32'(oValid), 32'd0);
        check("reset_stall", 32'(oFetchStall), 32'd0);
        check("reset_pc", oPc, 32'h0);
        check("reset_instr", oInstr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_vecs(0, vecs.size());

        // streaming: 20 back-to-back requests with decode always ready
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            check($sformatf("stream%0d_stall", c), 32'(oFetchStall), 32'd0);
            if (c >= 2 && c < 22) begin
                check($sformatf("stream%0d_valid", c), 32'(oValid), 32'd1);
                check($sformatf("stream%0d_pc", c), oPc, 32'h100 + 32'(4 * (c - 2)));
            end else if (c == 22) begin
                check("stream_end_valid", 32'(oValid), 32'd0);
            end
            drive(c < 20, 32'h100 + 32'(4 * c), 0, 1);
        end

        // flush with three queued and one in flight
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 32'h200 + 32'(4 * k), 0, 0);
        end
        @(negedge clk);
        check("fl_pre_valid", 32'(oValid), 32'd1);
        check("fl_pre_pc", oPc, 32'h200);
        check("fl_pre_stall", 32'(oFetchStall), 32'd1);
        drive(1, 32'h300, 1, 1);
        @(negedge clk);
        check("fl_t1_valid", 32'(oValid), 32'd0);
        check("fl_t1_stall", 32'(oFetchStall), 32'd0);
        drive(1, 32'h2000, 0, 0);
        @(negedge clk);
        check("fl_t2_valid", 32'(oValid), 32'd0);
        drive(0, 32'h0, 0, 0);
        @(negedge clk);
        check("fl_t3_valid", 32'(oValid), 32'd1);
        check("fl_t3_pc", oPc, 32'h2000);
        check("fl_t3_instr", oInstr, instr_of(32'h2000));
        drive(0, 32'h0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fl_after%0d_valid", k), 32'(oValid), 32'd0);
        end

        // fill, then push/pop near full for several pointer laps, then drain
        next_pc = 32'h400;
        exp_pc  = 32'h400;
        pops    = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            rdy = (c >= 5);
            fe  = (c < 21);
            if (oValid && rdy) begin
                check($sformatf("wrap%0d_pc", c), oPc, exp_pc);
                check($sformatf("wrap%0d_instr", c), oInstr, instr_of(exp_pc));
                exp_pc += 32'd4;
                pops++;
            end
            drive(fe, next_pc, 0, rdy);
            if (fe && !oFetchStall) next_pc += 32'd4;
        end
        check("wrap_all_drained", 32'(pops), (next_pc - 32'h400) >> 2);
        check("wrap_laps", 32'(pops >= 8), 32'd1);
        check("wrap_end_valid", 32'(oValid), 32'd0);

        // asynchronous reset between edges while the queue is full
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 32'h600 + 32'(4 * k), 0, 0);
        end
        @(negedge clk);
        check("ar_pre_valid", 32'(oValid), 32'd1);
        check("ar_pre_stall", 32'(oFetchStall), 32'd1);
        drive(0, 32'h0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 32'(oValid), 32'd0);
        check("ar_stall", 32'(oFetchStall), 32'd0);
        check("ar_pc", oPc, 32'h0);
        check("ar_instr", oInstr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vecs(0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
